// File: rtl/sprite_line_renderer_if.sv
// Bundle of the sprite line renderer's scan-side and ROM-side signals.
//
// Signalling (no valid/ready handshake is involved):
//   line_start  one-cycle pulse per video line, sent at least two Clk cycles
//               before the first pix_en of a visible line. DrawY, SpriteY,
//               SpriteX and sprite_sel are sampled only in that cycle.
//   pix_en      pixel strobe. DrawX names the column consumed in a cycle
//               with pix_en=1 and advances by one afterwards.
//   rom_addr    registered address {slot, row}. rom_data must answer it in
//               the same cycle, i.e. the ROM reads combinationally.
//   pixel_on    opaque-pixel flag, one pixel behind the strobed DrawX.
//   busy        renderer is not idle.
//   dbg_state   current FSM state: 0 IDLE, 1 FETCH, 2 ARMED, 3 SHIFT.
//
// Modports: master = video timing / ROM side, slave = renderer.
interface sprite_line_renderer_if #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
);
  localparam int ROW_W = $clog2(SPRITE_H);

  logic                line_start;
  logic                pix_en;
  logic [9:0]          DrawX;
  logic [9:0]          DrawY;
  logic [9:0]          SpriteX;
  logic [9:0]          SpriteY;
  logic [2:0]          sprite_sel;
  logic [ROW_W+2:0]    rom_addr;
  logic [SPRITE_W-1:0] rom_data;
  logic                pixel_on;
  logic                busy;
  logic [1:0]          dbg_state;

  modport master (
    output line_start, pix_en, DrawX, DrawY, SpriteX, SpriteY, sprite_sel, rom_data,
    input  rom_addr, pixel_on, busy, dbg_state
  );

  modport slave (
    input  line_start, pix_en, DrawX, DrawY, SpriteX, SpriteY, sprite_sel, rom_data,
    output rom_addr, pixel_on, busy, dbg_state
  );
endinterface

// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: on each line_start decides whether the current video
// row crosses the sprite, fetches that sprite row from a combinational ROM
// into a shift register, waits for DrawX to reach the sprite's left edge and
// then shifts one pixel out per pix_en strobe (MSB = leftmost pixel).
//
// Ports:
//   Clk      system clock, rising edge
//   Reset_n  asynchronous active-low reset
//   bus      sprite_line_renderer_if.slave (scan inputs, ROM port, pixel_on,
//            busy, dbg_state)
module sprite_line_renderer #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  sprite_line_renderer_if.slave  bus
);
  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int CNT_W = $clog2(SPRITE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ARMED = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SPRITE_W-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_sel_q;
  logic [ROW_W-1:0]    r_row_q;
  logic [9:0]          r_x_q;

  logic [9:0]          w_row;
  logic                w_hit;
  logic                w_last;

  // The subtraction wraps; the explicit DrawY >= SpriteY test is what keeps
  // rows above the sprite from looking like small positive offsets.
  assign w_row  = bus.DrawY - bus.SpriteY;
  assign w_hit  = (bus.DrawY >= bus.SpriteY) && (w_row < 10'(SPRITE_H));
  assign w_last = (r_cnt == CNT_W'(SPRITE_W - 1));

  // line_start wins over everything, including a pix_en in the same cycle.
  always_comb begin
    w_next = r_state;
    if (bus.line_start) begin
      w_next = w_hit ? FETCH : IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        FETCH:   w_next = ARMED;
        ARMED:   if (bus.pix_en && (bus.DrawX == r_x_q)) w_next = SHIFT;
        SHIFT:   if (bus.pix_en && w_last) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_sel_q <= '0;
      r_row_q <= '0;
      r_x_q   <= '0;
    end else if (bus.line_start) begin
      // Slot and left edge are frozen here so later changes wait a line.
      if (w_hit) begin
        r_sel_q <= bus.sprite_sel;
        r_row_q <= w_row[ROW_W-1:0];
        r_x_q   <= bus.SpriteX;
      end
    end else begin
      case (r_state)
        FETCH: begin
          r_shreg <= bus.rom_data;
          r_cnt   <= '0;
        end
        SHIFT: begin
          if (bus.pix_en) begin
            r_shreg <= {r_shreg[SPRITE_W-2:0], 1'b0};
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr  = {r_sel_q, r_row_q};
  // Gated by state so a stale shift register never shows outside SHIFT.
  assign bus.pixel_on  = (r_state == SHIFT) && r_shreg[SPRITE_W-1];
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;
  localparam int SW = 32;
  localparam int SH = 32;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_SHIFT = 2'd3;
  localparam logic [31:0] FILL = 32'h5A5A_A5A5;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  sprite_line_renderer_if #(.SPRITE_W(SW), .SPRITE_H(SH)) bus();

  sprite_line_renderer #(.SPRITE_W(SW), .SPRITE_H(SH)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Combinational ROM model
  logic [31:0] rom_mem [256];
  always_comb bus.rom_data = rom_mem[bus.rom_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_pix(input logic [9:0] d, input logic [9:0] sx,
                                     input logic [31:0] w, input bit in_range);
    int off;
    off = int'(d) - int'(sx);
    if (!in_range || off < 0 || off >= SW) return 1'b0;
    return w[SW-1-off];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_line(input logic [2:0] sel, input logic [9:0] sy, input logic [9:0] dy,
                            input logic [9:0] sx, input bit with_pix);
    @(negedge Clk);
    bus.line_start = 1'b1;
    bus.pix_en     = with_pix;
    bus.sprite_sel = sel;
    bus.SpriteY    = sy;
    bus.DrawY      = dy;
    bus.SpriteX    = sx;
    @(negedge Clk);
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
  endtask

  // Scan columns start..stop with random strobe gaps; sprite inputs are
  // scrambled meanwhile and must have no effect on the current line.
  task automatic scan(input logic [9:0] sx, input logic [31:0] w, input bit in_range,
                      input logic [9:0] start, input logic [9:0] stop, input string tag);
    logic [9:0] d = start;
    logic [0:0] last = 1'b0;
    logic [0:0] e;
    int guard = 0;
    while (d <= stop && guard < 400) begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s_pix_x%0d", tag, d), 32'(bus.pixel_on), 32'(e));
      end
      bus.sprite_sel = 3'($urandom_range(0, 7));
      bus.SpriteX    = 10'($urandom_range(0, 1023));
      bus.DrawX      = d;
      if ($urandom_range(0, 3) != 0) begin
        bus.pix_en = 1'b1;
        last = model_pix(d, sx, w, in_range);
        d++;
      end else begin
        bus.pix_en = 1'b0;
      end
      exp_q.push_back(last);
      guard++;
    end
    @(negedge Clk);
    bus.pix_en = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_pix_last", tag), 32'(bus.pixel_on), 32'(e));
    end
    check($sformatf("%s_scan_done", tag), 32'(d > stop), 32'd1);
  endtask

  // Start sprite slot 0 row (dy-100) at x=200 and strobe n columns from 200.
  task automatic enter_shift(input logic [9:0] dy, input int n);
    start_line(3'd0, 10'd100, dy, 10'd200, 1'b0);
    @(negedge Clk);
    for (int k = 0; k < n; k++) begin
      bus.DrawX  = 10'(200 + k);
      bus.pix_en = 1'b1;
      @(negedge Clk);
    end
    bus.pix_en = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  sel;
    logic [9:0]  sy;
    logic [9:0]  dy;
    logic [9:0]  sx;
    logic [31:0] word;
    bit          in_range;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd0, 10'd100, 10'd106, 10'd200, 32'h0007_F000, 1'b1, 8'd6};
    vecs[1] = '{3'd4, 10'd50,  10'd61,  10'd10,  32'h8000_0001, 1'b1, 8'd139};
    vecs[2] = '{3'd2, 10'd100, 10'd99,  10'd50,  32'h0,         1'b0, 8'd0};
    vecs[3] = '{3'd2, 10'd100, 10'd132, 10'd50,  32'h0,         1'b0, 8'd0};
    vecs[4] = '{3'd7, 10'd100, 10'd131, 10'd300, 32'hFFFF_FFFF, 1'b1, 8'd255};
    vecs[5] = '{3'd3, 10'd0,   10'd0,   10'd0,   32'hC000_0003, 1'b1, 8'd96};
    vecs[6] = '{3'd1, 10'd500, 10'd510, 10'd620, 32'hAAAA_AAAB, 1'b1, 8'd42};
    vecs[7] = '{3'd5, 10'd20,  10'd25,  10'd100, 32'h0,         1'b1, 8'd165};
    vecs[8] = '{3'd6, 10'd1000,10'd5,   10'd100, 32'h0,         1'b0, 8'd0};
    vecs[9] = '{3'd6, 10'd200, 10'd215, 10'd400, 32'h1234_5678, 1'b1, 8'd207};

    for (int a = 0; a < 256; a++) rom_mem[a] = FILL;
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    bus.DrawX      = '0;
    bus.DrawY      = '0;
    bus.SpriteX    = '0;
    bus.SpriteY    = '0;
    bus.sprite_sel = '0;

    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("reset_pixel_on", 32'(bus.pixel_on), 32'd0);
    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_state",    32'(bus.dbg_state), 32'(S_IDLE));
    Reset_n = 1'b1;

    // ---- table-driven lines ----
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].in_range) rom_mem[vecs[i].exp_addr] = vecs[i].word;
      start_line(vecs[i].sel, vecs[i].sy, vecs[i].dy, vecs[i].sx, 1'b0);
      if (vecs[i].in_range)
        check($sformatf("v%0d_rom_addr", i), 32'(bus.rom_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].in_range));
      check($sformatf("v%0d_state", i), 32'(bus.dbg_state),
            32'(vecs[i].in_range ? S_FETCH : S_IDLE));
      scan(vecs[i].sx, vecs[i].word, vecs[i].in_range,
           (vecs[i].sx >= 10'd5) ? vecs[i].sx - 10'd5 : 10'd0,
           vecs[i].sx + 10'd34, $sformatf("v%0d", i));
      check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 32'd0);
      if (vecs[i].in_range) rom_mem[vecs[i].exp_addr] = FILL;
    end

    // ---- abort: new line_start at cnt=10 ----
    rom_mem[6] = 32'hFFFF_FFFF;
    rom_mem[7] = 32'h0000_FFFF;
    enter_shift(10'd106, 11);
    check("abort_pre_state", 32'(bus.dbg_state), 32'(S_SHIFT));
    check("abort_pre_pix",   32'(bus.pixel_on),  32'd1);
    bus.line_start = 1'b1;
    bus.DrawY      = 10'd107;
    bus.SpriteY    = 10'd100;
    bus.SpriteX    = 10'd200;
    bus.sprite_sel = 3'd0;
    @(negedge Clk);
    bus.line_start = 1'b0;
    check("abort_state",    32'(bus.dbg_state), 32'(S_FETCH));
    check("abort_rom_addr", 32'(bus.rom_addr),  32'd7);
    check("abort_pix",      32'(bus.pixel_on),  32'd0);
    @(negedge Clk);
    check("abort_armed",     32'(bus.dbg_state), 32'(S_ARMED));
    check("abort_armed_pix", 32'(bus.pixel_on),  32'd0);
    scan(10'd200, 32'h0000_FFFF, 1'b1, 10'd195, 10'd234, "abort_row");

    // ---- collision: line_start + pix_en while shifting ----
    enter_shift(10'd106, 5);
    check("coll_pre_state", 32'(bus.dbg_state), 32'(S_SHIFT));
    bus.line_start = 1'b1;
    bus.pix_en     = 1'b1;
    bus.DrawX      = 10'd205;
    bus.DrawY      = 10'd99;
    @(negedge Clk);
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    check("coll_out_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("coll_out_busy",  32'(bus.busy),      32'd0);
    check("coll_out_pix",   32'(bus.pixel_on),  32'd0);
    enter_shift(10'd106, 5);
    bus.line_start = 1'b1;
    bus.pix_en     = 1'b1;
    bus.DrawX      = 10'd205;
    bus.DrawY      = 10'd108;
    @(negedge Clk);
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    check("coll_in_state",    32'(bus.dbg_state), 32'(S_FETCH));
    check("coll_in_rom_addr", 32'(bus.rom_addr),  32'd8);
    check("coll_in_pix",      32'(bus.pixel_on),  32'd0);

    // ---- asynchronous reset mid-shift ----
    enter_shift(10'd106, 4);
    check("rst_pre_pix", 32'(bus.pixel_on), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_async_pix",   32'(bus.pixel_on),  32'd0);
    check("rst_async_addr",  32'(bus.rom_addr),  32'd0);
    check("rst_async_busy",  32'(bus.busy),      32'd0);
    check("rst_async_state", 32'(bus.dbg_state), 32'(S_IDLE));
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.DrawX  = 10'(200 + k);
      bus.pix_en = 1'b1;
      @(negedge Clk);
      check($sformatf("rst_hold_pix%0d", k),  32'(bus.pixel_on), 32'd0);
      check($sformatf("rst_hold_busy%0d", k), 32'(bus.busy),     32'd0);
    end
    bus.pix_en = 1'b0;
    start_line(3'd0, 10'd100, 10'd106, 10'd200, 1'b0);
    check("rst_resume_state", 32'(bus.dbg_state), 32'(S_FETCH));
    check("rst_resume_addr",  32'(bus.rom_addr),  32'd6);
    scan(10'd200, 32'hFFFF_FFFF, 1'b1, 10'd198, 10'd234, "rst_resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_line_renderer.md
SPRITE_LINE_RENDERER -- requirements
Module: sprite_line_renderer

Interface
REQ-001 The block SHALL have parameter SPRITE_W, default 32: sprite width in pixels, which is also the ROM word width.
REQ-002 The block SHALL have parameter SPRITE_H, default 32: sprite height in rows (rows per sprite slot in the ROM).
REQ-003 Port Clk, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-004 Port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port line_start, input, 1 bit: one-cycle pulse, issued at least 2 Clk cycles before the first pix_en of a visible line.
REQ-006 Port pix_en, input, 1 bit: pixel strobe; DrawX advances by one after each cycle in which pix_en is high.
REQ-007 Port DrawX, input, 10 bits: current pixel column.
REQ-008 Port DrawY, input, 10 bits: current pixel row.
REQ-009 Port SpriteX, input, 10 bits: column of the sprite's left edge.
REQ-010 Port SpriteY, input, 10 bits: row of the sprite's top edge.
REQ-011 Port sprite_sel, input, 3 bits: sprite slot index, 0..7.
REQ-012 Port rom_addr, output, 8 bits: combinational sprite ROM address.
REQ-013 Port rom_data, input, 32 bits: ROM row data; MSB is the leftmost pixel.
REQ-014 Port pixel_on, output, 1 bit: sprite pixel opaque.
REQ-015 Port busy, output, 1 bit: renderer is not IDLE.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, FETCH, ARMED and SHIFT.
REQ-017 On line_start in any state, the block SHALL compute row = DrawY - SpriteY as a 10-bit unsigned value.
- If DrawY >= SpriteY and row < SPRITE_H: capture sel_q = sprite_sel, row_q = row[4:0] and x_q = SpriteX, and go to FETCH.
- Otherwise: go to IDLE.
REQ-018 rom_addr SHALL equal {sel_q, row_q}, i.e. sel_q*32 + row_q, driven from registers; it is valid from the cycle after line_start.
REQ-019 In FETCH (exactly one cycle), the block SHALL load rom_data into a 32-bit shift register shreg, set the pixel counter cnt = 0, and go to ARMED.
- A ROM with zero-cycle (combinational) read is required.
REQ-020 In ARMED, on a cycle with pix_en=1 and DrawX == x_q, the block SHALL go to SHIFT; DrawX != x_q SHALL keep it in ARMED.
REQ-021 In SHIFT, pixel_on SHALL equal shreg[31].
- On each pix_en: shift shreg left by one (zero fill) and increment cnt.
- When cnt reaches SPRITE_W-1 and pix_en is high: go to IDLE.
REQ-022 pixel_on SHALL be 0 in every state other than SHIFT.
REQ-023 Output latency SHALL be one pixel: pixel_on corresponds to the pixel at x_q + k, where k is the number of pix_en strobes seen since entering SHIFT. The top level delays colour select accordingly.
REQ-024 busy SHALL be 1 whenever the state is not IDLE.
REQ-025 When line_start and pix_en are high in the same cycle, line_start SHALL take priority and no shift SHALL occur.
REQ-026 A line_start arriving in FETCH, ARMED or SHIFT SHALL abort the current line and re-evaluate per REQ-017.
REQ-027 Changes to SpriteX and sprite_sel after line_start SHALL be ignored until the next line_start.
REQ-028 A sprite extending past column 639 SHALL keep shifting until cnt completes or the next line_start arrives; no clipping is performed inside the block.
REQ-029 An all-zero ROM row SHALL still pass through SHIFT, with pixel_on held at 0 for the whole row.
REQ-030 The 10-bit subtraction SHALL wrap; the DrawY >= SpriteY check is what rejects negative rows.

Reset
REQ-031 Reset_n=0 SHALL asynchronously force:
- state = IDLE, shreg = 0, cnt = 0;
- sel_q = 0, row_q = 0, x_q = 0;
- hence rom_addr = 0, pixel_on = 0, busy = 0.
REQ-032 An assertion of reset mid-SHIFT SHALL drop pixel_on to 0 immediately; the block resumes only at the next line_start after Reset_n=1.

Verification
REQ-033 Basic row fetch:
- Stimulus: sel=0, SpriteY=100, DrawY=106, SpriteX=200, ROM returns 0x0007F000.
- Response: rom_addr=6; pixel_on=1 for exactly 7 strobes, offsets 13..19 after entering SHIFT.
REQ-034 Slot addressing:
- Stimulus: sel=4, SpriteY=50, DrawY=61.
- Response: rom_addr=139.
REQ-035 Out-of-range rows:
- Stimulus: DrawY=99 with SpriteY=100 (below range), and DrawY=132 with SpriteY=100 (above range).
- Response: state stays IDLE; busy=0; pixel_on=0 for the whole line.
REQ-036 Abort on new line:
- Stimulus: line_start asserted at cnt=10 in SHIFT, with DrawY in range.
- Response: next cycle FETCH with the new row_q; pixel_on=0 until the next SHIFT.
REQ-037 Collision:
- Stimulus: line_start and pix_en high in the same cycle while in SHIFT.
- Response: no shift occurs; state becomes FETCH or IDLE per REQ-017.
REQ-038 Reset mid-line:
- Stimulus: Reset_n pulsed low mid-SHIFT, with shreg=0xFFFFFFFF.
- Response: pixel_on=0 and rom_addr=0 without waiting for a Clk edge; busy=0.
